// File: rtl/incubator.sv
// Incubator temperature controller: an `ac` FSM picks heat/cool with hysteresis, a `fan` FSM picks cooler speed.
// Optional build macro INCUBATOR_SENSOR_REG_EN registers the sensor input before the FSMs (2-cycle latency).

module incubator_ac #(
  parameter logic signed [7:0] T_HEAT_ON  = 8'sd15,
  parameter logic signed [7:0] T_HEAT_OFF = 8'sd30,
  parameter logic signed [7:0] T_COOL_ON  = 8'sd35,
  parameter logic signed [7:0] T_COOL_OFF = 8'sd25
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic signed [7:0] temp,
  output logic [1:0]        cur,
  output logic [1:0]        nxt
);
  typedef enum logic [1:0] {IDLE = 2'd0, HEAT = 2'd1, COOL = 2'd2} ac_state_e;

  ac_state_e state, state_nx;

  always_ff @(posedge clk) begin
    if (rstn) state <= IDLE;
    else      state <= state_nx;
  end

  // HEAT and COOL only exit to IDLE, so a heat/cool swap always spends a cycle in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (temp < T_HEAT_ON)      state_nx = HEAT;
        else if (temp > T_COOL_ON) state_nx = COOL;
      end
      HEAT:    if (temp >= T_HEAT_OFF) state_nx = IDLE;
      COOL:    if (temp < T_COOL_OFF)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign cur = state;
  assign nxt = state_nx;
endmodule

module incubator_fan #(
  parameter logic signed [7:0] T_COOL_ON = 8'sd35,
  parameter logic signed [7:0] T_MID     = 8'sd40,
  parameter logic signed [7:0] T_HIGH    = 8'sd45
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic signed [7:0] temp,
  input  logic              cool_next,
  output logic [3:0]        crs
);
  typedef enum logic [1:0] {OFF = 2'd0, LOW = 2'd1, MID = 2'd2, HIGH = 2'd3} fan_state_e;

  fan_state_e state, state_nx;

  always_ff @(posedge clk) begin
    if (rstn) state <= OFF;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      OFF:  if (cool_next) state_nx = LOW;
      LOW:  if (temp > T_MID) state_nx = MID;
      MID: begin
        if (temp > T_HIGH)         state_nx = HIGH;
        else if (temp < T_COOL_ON) state_nx = LOW;
      end
      HIGH: if (temp < T_MID) state_nx = MID;
      default: state_nx = OFF;
    endcase
    // The fan can only spin while the ac FSM is (or is about to stay) cooling.
    if (!cool_next) state_nx = OFF;
  end

  always_comb begin
    crs = 4'd0;
    case (state)
      LOW:     crs = 4'd4;
      MID:     crs = 4'd6;
      HIGH:    crs = 4'd8;
      default: crs = 4'd0;
    endcase
  end
endmodule

module incubator #(
  parameter logic signed [7:0] T_HEAT_ON  = 8'sd15,
  parameter logic signed [7:0] T_HEAT_OFF = 8'sd30,
  parameter logic signed [7:0] T_COOL_ON  = 8'sd35,
  parameter logic signed [7:0] T_COOL_OFF = 8'sd25,
  parameter logic signed [7:0] T_MID      = 8'sd40,
  parameter logic signed [7:0] T_HIGH     = 8'sd45
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic signed [7:0] sensor,
  output logic              heater,
  output logic              cooler,
  output logic [3:0]        CRS
);
  logic signed [7:0] temp;
  logic [1:0]        ac_cur, ac_nxt;

`ifdef INCUBATOR_SENSOR_REG_EN
  logic signed [7:0] sensor_q;
  always_ff @(posedge clk) begin
    if (rstn) sensor_q <= 8'sd0;
    else      sensor_q <= sensor;
  end
  assign temp = sensor_q;
`else
  assign temp = sensor;
`endif

  incubator_ac #(
    .T_HEAT_ON (T_HEAT_ON),
    .T_HEAT_OFF(T_HEAT_OFF),
    .T_COOL_ON (T_COOL_ON),
    .T_COOL_OFF(T_COOL_OFF)
  ) ac (
    .clk (clk),
    .rstn(rstn),
    .temp(temp),
    .cur (ac_cur),
    .nxt (ac_nxt)
  );

  incubator_fan #(
    .T_COOL_ON(T_COOL_ON),
    .T_MID    (T_MID),
    .T_HIGH   (T_HIGH)
  ) fan (
    .clk      (clk),
    .rstn     (rstn),
    .temp     (temp),
    .cool_next(ac_nxt == 2'd2),
    .crs      (CRS)
  );

  assign heater = (ac_cur == 2'd1);
  assign cooler = (ac_cur == 2'd2);
endmodule

// File: tb/tb_incubator.sv
// Bench for incubator: directed vector table, temperature ramps and a random walk against a mode/level model.
module tb_incubator;
  logic              clk = 1'b0;
  logic              rstn;
  logic signed [7:0] sensor;
  logic              heater, cooler;
  logic [3:0]        CRS;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 heating, 2 cooling; fan level 0..3 indexes the speed table.
  int m_mode = 0;
  int m_lvl  = 0;
  int speed_of[4] = '{0, 4, 6, 8};
  int up_at[4]    = '{0, 40, 45, 999};
  int down_at[4]  = '{0, -999, 35, 40};

  typedef struct {
    bit rst;
    int t;
    bit h;
    bit c;
    int crs;
  } vec_t;
  vec_t vecs[$];

  incubator dut (
    .clk   (clk),
    .rstn  (rstn),
    .sensor(sensor),
    .heater(heater),
    .cooler(cooler),
    .CRS   (CRS)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input bit rst, input int t);
    int nm;
    if (rst) begin
      m_mode = 0;
      m_lvl  = 0;
      return;
    end
    nm = m_mode;
    if (m_mode == 0 && t < 15)       nm = 1;
    else if (m_mode == 0 && t > 35)  nm = 2;
    else if (m_mode == 1 && t >= 30) nm = 0;
    else if (m_mode == 2 && t < 25)  nm = 0;
    if (nm != 2)                 m_lvl = 0;
    else if (m_lvl == 0)         m_lvl = 1;
    else if (t > up_at[m_lvl])   m_lvl = m_lvl + 1;
    else if (t < down_at[m_lvl]) m_lvl = m_lvl - 1;
    m_mode = nm;
  endfunction

  task automatic step(input bit rst, input int t);
    rstn   = rst;
    sensor = 8'(t);
    @(posedge clk);
    #1;
    model_step(rst, t);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " heater"}, int'(heater), int'(m_mode == 1));
    chk({tag, " cooler"}, int'(cooler), int'(m_mode == 2));
    chk({tag, " CRS"}, int'(CRS), speed_of[m_lvl]);
    chk({tag, " exclusive"}, int'(heater & cooler), 0);
    chk({tag, " crs_gated"}, int'((CRS != 4'd0) & ~cooler), 0);
  endtask

  initial begin
    int t;
    rstn   = 1'b1;
    sensor = -8'sd10;

    vecs.push_back('{1, -10, 0, 0, 0});
    vecs.push_back('{0, -10, 1, 0, 0});
    vecs.push_back('{0,  29, 1, 0, 0});
    vecs.push_back('{0,  30, 0, 0, 0});
    vecs.push_back('{0,  35, 0, 0, 0});
    vecs.push_back('{0,  35, 0, 0, 0});
    vecs.push_back('{0,  36, 0, 1, 4});
    vecs.push_back('{0,  25, 0, 1, 4});
    vecs.push_back('{0,  40, 0, 1, 4});
    vecs.push_back('{0,  41, 0, 1, 6});
    vecs.push_back('{0,  35, 0, 1, 6});
    vecs.push_back('{0,  46, 0, 1, 8});
    vecs.push_back('{0,  60, 0, 1, 8});
    vecs.push_back('{0,  39, 0, 1, 6});
    vecs.push_back('{0,  34, 0, 1, 4});
    vecs.push_back('{0,  24, 0, 0, 0});
    vecs.push_back('{0,  14, 1, 0, 0});
    vecs.push_back('{0,  10, 1, 0, 0});
    vecs.push_back('{0,  50, 0, 0, 0});
    vecs.push_back('{0,  50, 0, 1, 4});
    vecs.push_back('{0,  50, 0, 1, 6});
    vecs.push_back('{0,  50, 0, 1, 8});
    vecs.push_back('{1,  50, 0, 0, 0});
    vecs.push_back('{0,  50, 0, 1, 4});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].t);
      chk($sformatf("vec%0d heater", i), int'(heater), int'(vecs[i].h));
      chk($sformatf("vec%0d cooler", i), int'(cooler), int'(vecs[i].c));
      chk($sformatf("vec%0d CRS", i), int'(CRS), vecs[i].crs);
    end

    // Reset then full ramps up and down, checked against the model every cycle.
    step(1, -10);
    check_model("ramp_rst");
    for (int v = -10; v <= 60; v++) begin
      step(0, v);
      check_model($sformatf("up%0d", v));
    end
    for (int v = 60; v >= -10; v--) begin
      step(0, v);
      check_model($sformatf("down%0d", v));
    end

    // Hold boundary values for several cycles.
    step(1, 20);
    for (int i = 0; i < 4; i++) begin step(0, 35); check_model("hold35_idle"); end
    step(0, 36);
    for (int i = 0; i < 4; i++) begin step(0, 25); check_model("hold25_cool"); end
    step(0, 5);
    step(0, 5);
    for (int i = 0; i < 3; i++) begin step(0, 30); check_model("hold30_heat"); end
    chk("hold30_heater_off", int'(heater), 0);

    // Random walk with occasional jumps and resets.
    t = 20;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) t = int'($urandom_range(0, 255)) - 128;
      else t = t + int'($urandom_range(0, 6)) - 3;
      if (t > 127) t = 127;
      if (t < -128) t = -128;
      step($urandom_range(0, 49) == 0, t);
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
